// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: base opcodes, NOP encoding, field bit positions
// and the packed split-field struct used by the decode-side pipeline stages.
package rv32_pkg;

    localparam logic [6:0] OP_LOAD     = 7'h03;
    localparam logic [6:0] OP_MISC_MEM = 7'h0F;
    localparam logic [6:0] OP_IMM      = 7'h13;
    localparam logic [6:0] OP_AUIPC    = 7'h17;
    localparam logic [6:0] OP_STORE    = 7'h23;
    localparam logic [6:0] OP_OP       = 7'h33;
    localparam logic [6:0] OP_LUI      = 7'h37;
    localparam logic [6:0] OP_BRANCH   = 7'h63;
    localparam logic [6:0] OP_JALR     = 7'h67;
    localparam logic [6:0] OP_JAL      = 7'h6F;
    localparam logic [6:0] OP_SYSTEM   = 7'h73;

    localparam logic [31:0] RV32_NOP = 32'h0000_0013;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int CSR_LSB    = 20;
    localparam int FUNCT7_LSB = 25;
    localparam int UPPER_LSB  = 7;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] csr;
        logic [24:0] instr_31_7;
    } rv32_fields_t;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_STORE, OP_OP,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32_field_split.sv
// Combinational split of an RV32 word into decode fields plus an illegal flag;
// kill substitutes the NOP encoding and suppresses illegal. No state, no backpressure.
module rv32_field_split
    import rv32_pkg::*;
#(
    parameter logic [31:0] NOP = RV32_NOP
) (
    input  logic [31:0]  i_instr,
    input  logic         i_kill,
    output rv32_fields_t o_fields,
    output logic         o_illegal
);

    logic [31:0] w_instr;

    assign w_instr = i_kill ? NOP : i_instr;

    assign o_fields.opcode     = w_instr[OPCODE_LSB +: 7];
    assign o_fields.funct3     = w_instr[FUNCT3_LSB +: 3];
    assign o_fields.funct7     = w_instr[FUNCT7_LSB +: 7];
    assign o_fields.rs1        = w_instr[RS1_LSB +: 5];
    assign o_fields.rs2        = w_instr[RS2_LSB +: 5];
    assign o_fields.rd         = w_instr[RD_LSB +: 5];
    assign o_fields.csr        = w_instr[CSR_LSB +: 12];
    assign o_fields.instr_31_7 = w_instr[UPPER_LSB +: 25];

    // All legal base opcodes end in 2'b11, but compressed-looking words are named explicitly.
    assign o_illegal = !i_kill &&
                       ((w_instr[1:0] != 2'b11) || !is_legal_opcode(w_instr[OPCODE_LSB +: 7]));

endmodule

// File: rtl/rv32_instr_queue_decode.sv
// Fetch-to-decode FIFO (DEPTH entries, FWFT, push visible one cycle after its edge, no bypass)
// with head field split; fetch sees ready while not full or while the head is being popped.
module rv32_instr_queue_decode
    import rv32_pkg::*;
#(
    parameter int          INSTRUCTION_WIDTH = 32,
    parameter int          PC_WIDTH          = 32,
    parameter int          DEPTH             = 4,
    parameter logic [31:0] NOP_INSTR         = 32'h0000_0013
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         flush_in,
    input  logic                         instr_valid_in,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
    input  logic [PC_WIDTH-1:0]          pc_in,
    output logic                         instr_ready_out,
    output logic                         dec_valid_out,
    input  logic                         dec_ready_in,
    output logic [PC_WIDTH-1:0]          pc_out,
    output logic [6:0]                   opcode_out,
    output logic [2:0]                   funct3_out,
    output logic [6:0]                   funct7_out,
    output logic [4:0]                   rs1_addr_out,
    output logic [4:0]                   rs2_addr_out,
    output logic [4:0]                   rd_addr_out,
    output logic [11:0]                  csr_addr_out,
    output logic [24:0]                  instr_31_7_out,
    output logic                         illegal_out,
    output logic [$clog2(DEPTH):0]       count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [INSTRUCTION_WIDTH-1:0] r_instr_mem [DEPTH];
    logic [PC_WIDTH-1:0]          r_pc_mem    [DEPTH];
    logic [AW-1:0]                r_wr_ptr;
    logic [AW-1:0]                r_rd_ptr;
    logic [CW-1:0]                r_count;
    logic [PC_WIDTH-1:0]          r_last_pc;

    logic         w_full;
    logic         w_push;
    logic         w_pop;
    logic         w_write;
    rv32_fields_t w_fields;

    assign w_full          = (r_count == DEPTH_C);
    assign dec_valid_out   = (r_count != '0) && !flush_in;
    assign w_pop           = dec_valid_out && dec_ready_in;
    assign instr_ready_out = !w_full || w_pop;
    assign w_push          = instr_valid_in && instr_ready_out;
    // A push during flush still handshakes but is discarded.
    assign w_write         = w_push && !flush_in;

    always_ff @(posedge clk_in) begin
        if (w_write) begin
            r_instr_mem[r_wr_ptr] <= instr_in;
            r_pc_mem[r_wr_ptr]    <= pc_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_last_pc <= '0;
        end else if (flush_in) begin
            r_count  <= '0;
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_last_pc <= r_pc_mem[r_rd_ptr];
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    rv32_field_split #(
        .NOP (NOP_INSTR)
    ) u_split (
        .i_instr   (r_instr_mem[r_rd_ptr]),
        .i_kill    (!dec_valid_out),
        .o_fields  (w_fields),
        .o_illegal (illegal_out)
    );

    assign pc_out         = dec_valid_out ? r_pc_mem[r_rd_ptr] : r_last_pc;
    assign opcode_out     = w_fields.opcode;
    assign funct3_out     = w_fields.funct3;
    assign funct7_out     = w_fields.funct7;
    assign rs1_addr_out   = w_fields.rs1;
    assign rs2_addr_out   = w_fields.rs2;
    assign rd_addr_out    = w_fields.rd;
    assign csr_addr_out   = w_fields.csr;
    assign instr_31_7_out = w_fields.instr_31_7;
    assign count_out      = r_count;

endmodule
